// File: rtl/vga_sync_gen.sv
// Raster timing generator for 640x480@60 Hz from a 100 MHz system clock.
// A clock divider produces a one-clock pixel enable; horizontal and vertical
// counters advance on it, and sync/blanking/frame decodes are taken
// combinationally from the registered counters so they line up with
// hCount/vCount in the same cycle.
//
// Ports:
//   clk        system clock (100 MHz)
//   rst        synchronous active-high reset
//   pix_en     one-clock pulse per pixel period; counters advance on it
//   hCount     horizontal position, 0..H_TOTAL-1
//   vCount     vertical position, 0..V_TOTAL-1
//   hSync      active-low horizontal sync
//   vSync      active-low vertical sync
//   bright     high inside the visible window
//   frame_tick one-clock pulse on the last pixel of each frame
module vga_sync_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0]      VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0]      HVisStart = 10'(H_VIS_START);
  localparam logic [9:0]      HVisEnd   = 10'(H_VIS_END);
  localparam logic [9:0]      VVisStart = 10'(V_VIS_START);
  localparam logic [9:0]      VVisEnd   = 10'(V_VIS_END);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            pix_en_w;
  logic            line_end;
  logic            frame_end;

  always_comb begin
    pix_en_w  = (div_q == DivLast);
    line_end  = (h_q == HLast);
    frame_end = (v_q == VLast);

    div_d = pix_en_w ? '0 : div_q + DivW'(1);
    h_d   = h_q;
    v_d   = v_q;

    // Explicit wraps at H_TOTAL-1 / V_TOTAL-1; never rely on 10-bit overflow.
    if (pix_en_w) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    pix_en     = pix_en_w;
    hCount     = h_q;
    vCount     = v_q;
    hSync      = ~(h_q < HSyncEnd);
    vSync      = ~(v_q < VSyncEnd);
    bright     = (h_q >= HVisStart) && (h_q < HVisEnd) &&
                 (v_q >= VVisStart) && (v_q < VVisEnd);
    frame_tick = pix_en_w && line_end && frame_end;
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. The default-parameter instance covers reset, pixel
// enable cadence, counter hold and one full 800-pixel line. A reduced-raster
// instance (16x8 pixels, 4 clks/pixel, 512 clks/frame) covers the visible
// window, frame wrap, frame_tick and mid-frame reset within a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Default 640x480 instance.
  logic       d_pix, d_hs, d_vs, d_br, d_ft;
  logic [9:0] d_h, d_v;

  vga_sync_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (d_pix),
    .hCount     (d_h),
    .vCount     (d_v),
    .hSync      (d_hs),
    .vSync      (d_vs),
    .bright     (d_br),
    .frame_tick (d_ft)
  );

  // Reduced raster: visible h 4..13, v 3..6; sync h 0..1, v 0..1.
  logic       s_pix, s_hs, s_vs, s_br, s_ft;
  logic [9:0] s_h, s_v;

  vga_sync_gen #(
    .CLK_DIV     (4),
    .H_TOTAL     (16),
    .H_SYNC      (2),
    .H_VIS_START (4),
    .H_VIS_END   (14),
    .V_TOTAL     (8),
    .V_SYNC      (2),
    .V_VIS_START (3),
    .V_VIS_END   (7)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (s_pix),
    .hCount     (s_h),
    .vCount     (s_v),
    .hSync      (s_hs),
    .vSync      (s_vs),
    .bright     (s_br),
    .frame_tick (s_ft)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-clock reset; on return the counters sit at (0,0) with div=0.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] exp_flags;
    rst = 1'b1;
    repeat (5) step();
    exp_flags = 5'b00000;  // pix_en, hSync, vSync, bright, frame_tick
    nvec++;
    if ({d_pix, d_hs, d_vs, d_br, d_ft} !== exp_flags) begin
      nmis++;
      $display("FAIL reset_flags_default: got %b want %b",
               {d_pix, d_hs, d_vs, d_br, d_ft}, exp_flags);
    end
    nvec++;
    if (d_h !== 10'd0 || d_v !== 10'd0) begin
      nmis++;
      $display("FAIL reset_counters_default: got h=%0d v=%0d want 0 0", d_h, d_v);
    end
    nvec++;
    if ({s_pix, s_hs, s_vs, s_br, s_ft} !== exp_flags || s_h !== 10'd0 || s_v !== 10'd0) begin
      nmis++;
      $display("FAIL reset_small: got flags=%b h=%0d v=%0d want 00000 0 0",
               {s_pix, s_hs, s_vs, s_br, s_ft}, s_h, s_v);
    end
    rst = 1'b0;
    // pix_en at clks 3,7,11 after release; hCount becomes 1 at clk 4.
    for (int k = 1; k <= 12; k++) begin
      logic       exp_pix;
      logic [9:0] exp_h;
      step();
      exp_pix = (k % 4 == 3);
      exp_h   = 10'(k / 4);
      nvec++;
      if (d_pix !== exp_pix) begin
        nmis++;
        $display("FAIL pix_en_cadence clk%0d: got %b want %b", k, d_pix, exp_pix);
      end
      nvec++;
      if (d_h !== exp_h) begin
        nmis++;
        $display("FAIL hcount_after_release clk%0d: got %0d want %0d", k, d_h, exp_h);
      end
    end
  endtask

  task automatic test_counter_hold();
    do_reset();
    repeat (41) step();
    for (int k = 41; k <= 43; k++) begin
      nvec++;
      if (d_h !== 10'd10 || d_pix !== (k == 43)) begin
        nmis++;
        $display("FAIL counter_hold clk%0d: got h=%0d pix=%b want h=10 pix=%b",
                 k, d_h, d_pix, (k == 43));
      end
      step();
    end
    nvec++;
    if (d_h !== 10'd11) begin
      nmis++;
      $display("FAIL counter_advance: got h=%0d want 11", d_h);
    end
  endtask

  task automatic test_horizontal();
    int         lo  = 0;
    int         hi  = 0;
    int         bad = 0;
    logic [9:0] bad_h = '0;
    logic [9:0] bad_e = '0;
    do_reset();
    for (int k = 0; k < 3200; k++) begin
      logic [9:0] eh;
      eh = 10'(k / 4);
      if (d_h !== eh || d_v !== 10'd0) begin
        if (bad == 0) begin
          bad_h = d_h;
          bad_e = eh;
        end
        bad++;
      end
      if (d_hs === 1'b0) lo++;
      else hi++;
      step();
    end
    nvec++;
    if (bad != 0) begin
      nmis++;
      $display("FAIL line_sequence: %0d bad samples, first got h=%0d want %0d",
               bad, bad_h, bad_e);
    end
    nvec++;
    if (lo != 384) begin
      nmis++;
      $display("FAIL hsync_low_clks: got %0d want 384", lo);
    end
    nvec++;
    if (hi != 2816) begin
      nmis++;
      $display("FAIL hsync_high_clks: got %0d want 2816", hi);
    end
    nvec++;
    if (d_h !== 10'd0 || d_v !== 10'd1) begin
      nmis++;
      $display("FAIL line_wrap: got h=%0d v=%0d want 0 1", d_h, d_v);
    end
  endtask

  task automatic test_visible();
    int         cnt   = 0;
    int         first = -1;
    int         last  = -1;
    int         viol  = 0;
    logic [9:0] fh = '0, fv = '0, lh = '0, lv = '0;
    do_reset();
    for (int k = 0; k < 512; k++) begin
      if (s_br === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = k;
          fh = s_h;
          fv = s_v;
        end
        last = k;
        lh   = s_h;
        lv   = s_v;
        if (s_hs !== 1'b1 || s_vs !== 1'b1) viol++;
      end
      step();
    end
    nvec++;
    if (cnt != 160) begin
      nmis++;
      $display("FAIL bright_clks: got %0d want 160", cnt);
    end
    nvec++;
    if (first != 208 || fh !== 10'd4 || fv !== 10'd3) begin
      nmis++;
      $display("FAIL bright_first: got clk%0d (%0d,%0d) want clk208 (4,3)", first, fh, fv);
    end
    nvec++;
    if (last != 439 || lh !== 10'd13 || lv !== 10'd6) begin
      nmis++;
      $display("FAIL bright_last: got clk%0d (%0d,%0d) want clk439 (13,6)", last, lh, lv);
    end
    nvec++;
    if (viol != 0) begin
      nmis++;
      $display("FAIL bright_during_sync: got %0d clks want 0", viol);
    end
  endtask

  task automatic test_frame();
    int ticks = 0;
    int t0    = -1;
    int t1    = -1;
    int vs_lo = 0;
    do_reset();
    for (int k = 0; k < 1100; k++) begin
      if (k < 512 && s_vs === 1'b0) vs_lo++;
      if (s_ft === 1'b1) begin
        ticks++;
        if (t0 < 0) t0 = k;
        else if (t1 < 0) t1 = k;
        nvec++;
        if (s_h !== 10'd15 || s_v !== 10'd7 || s_pix !== 1'b1) begin
          nmis++;
          $display("FAIL tick_position clk%0d: got (%0d,%0d) pix=%b want (15,7) pix=1",
                   k, s_h, s_v, s_pix);
        end
      end
      if (k == 512) begin
        nvec++;
        if (s_h !== 10'd0 || s_v !== 10'd0 || s_vs !== 1'b0) begin
          nmis++;
          $display("FAIL frame_wrap: got (%0d,%0d) vSync=%b want (0,0) vSync=0",
                   s_h, s_v, s_vs);
        end
      end
      step();
    end
    nvec++;
    if (ticks != 2 || t0 != 511 || t1 != 1023) begin
      nmis++;
      $display("FAIL tick_count: got %0d ticks at clk%0d,clk%0d want 2 at clk511,clk1023",
               ticks, t0, t1);
    end
    nvec++;
    if (vs_lo != 128) begin
      nmis++;
      $display("FAIL vsync_low_clks: got %0d want 128", vs_lo);
    end
  endtask

  task automatic test_mid_reset();
    int first = -1;
    int extra = 0;
    do_reset();
    repeat (361) step();
    nvec++;
    if (s_h !== 10'd10 || s_v !== 10'd5) begin
      nmis++;
      $display("FAIL mid_position: got (%0d,%0d) want (10,5)", s_h, s_v);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if (s_h !== 10'd0 || s_v !== 10'd0 || s_pix !== 1'b0 || s_ft !== 1'b0) begin
      nmis++;
      $display("FAIL mid_reset_state: got (%0d,%0d) pix=%b tick=%b want (0,0) pix=0 tick=0",
               s_h, s_v, s_pix, s_ft);
    end
    for (int k = 1; k <= 600; k++) begin
      step();
      if (k == 2 || k == 3) begin
        nvec++;
        if (s_pix !== (k == 3)) begin
          nmis++;
          $display("FAIL mid_reset_div clk%0d: got pix=%b want %b", k, s_pix, (k == 3));
        end
      end
      if (s_ft === 1'b1) begin
        if (first < 0) first = k;
        else extra++;
      end
    end
    nvec++;
    if (first != 511 || extra != 0) begin
      nmis++;
      $display("FAIL mid_reset_tick: got first clk%0d extra %0d want clk511 extra 0",
               first, extra);
    end
  endtask

  initial begin
    test_reset();
    test_counter_hold();
    test_horizontal();
    test_visible();
    test_frame();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator that drives the pixel-coordinate interface consumed by `vga_bitchange`. It produces `hCount`, `vCount`, `bright`, and the active-low `hSync`/`vSync` for 640x480@60 Hz from the 100 MHz board clock. It also produces a pixel enable and a once-per-frame tick for game logic. It sits between the top level and the pixel/colour generator, and its sync outputs go straight to the VGA connector pins.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (100 MHz -> 25 MHz)
- `H_TOTAL`, 800, pixel clocks per line
- `H_SYNC`, 96, hSync low width in pixels (hCount 0..95)
- `H_VIS_START`, 144, first visible hCount
- `H_VIS_END`, 784, first non-visible hCount after the active region
- `V_TOTAL`, 525, lines per frame
- `V_SYNC`, 2, vSync low width in lines (vCount 0..1)
- `V_VIS_START`, 35, first visible vCount
- `V_VIS_END`, 515, first non-visible vCount after the active region
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `pix_en`  out  1  one-clk pulse each pixel period; counters advance on it
- `hCount`  out  10  horizontal position, 0..H_TOTAL-1
- `vCount`  out  10  vertical position, 0..V_TOTAL-1
- `hSync`  out  1  active-low horizontal sync
- `vSync`  out  1  active-low vertical sync
- `bright`  out  1  high inside the visible window
- `frame_tick`  out  1  one-clk pulse on the last pixel of each frame

## Operation
- Divider counter `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div == CLK_DIV-1), decoded combinationally from the registered `div`.
- On a clk edge with `pix_en` high:
  - If hCount == H_TOTAL-1: hCount <= 0.
    - If vCount == V_TOTAL-1: vCount <= 0; else vCount <= vCount+1.
  - Else hCount <= hCount+1; vCount holds.
- When `pix_en` is low, hCount and vCount hold.
- Decodes are combinational from the registered counters, so they are aligned with `hCount`/`vCount` in the same cycle:
  - hSync = ~(hCount < H_SYNC)
  - vSync = ~(vCount < V_SYNC)
  - bright = (H_VIS_START <= hCount < H_VIS_END) && (V_VIS_START <= vCount < V_VIS_END)
  - frame_tick = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1
- Visible window is hCount 144..783 and vCount 35..514; horizontal screen centre is hCount 463.
- Width rules:
  - Counters are 10-bit unsigned.
  - Comparisons are unsigned.
  - Parameters must satisfy H_TOTAL, V_TOTAL <= 1024; the block never relies on natural 10-bit overflow.
- States are implicit in the counters: horizontal sync -> back porch -> active -> front porch, repeated per line; vertical uses the same sequence per line count.

## Timing
- Reset (synchronous, `rst` high at a clk edge): div=0, hCount=0, vCount=0.
  - Resulting outputs: pix_en=0, hSync=0, vSync=0, bright=0, frame_tick=0.
- Reset has priority over counting.
- Reset asserted mid-frame restarts the frame at (0,0) on the next edge, with no partial tick.
- First `pix_en` occurs CLK_DIV-1 = 3 clks after reset deasserts.
- hCount first reads 1 at the edge after that `pix_en`.
- Pixel period = 4 clks.
- Line period = 3200 clks; hSync low for 384 clks per line.
- Frame period = 800*525*4 = 1,680,000 clks; vSync low for 2 lines = 6400 clks.
- Simultaneous line wrap and frame wrap: both counters go to 0 on the same edge, and frame_tick is high in the cycle before that edge.
- `bright` is never high while hSync or vSync is low.

## Test plan
- **Reset values:** hold rst 5 clks -> hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_en=0, frame_tick=0. Release -> pix_en pulses at clk 3, 7, 11, ... after release, each exactly 1 clk wide.
- **Horizontal timing:** run one line -> hCount goes 0..799 then 0. hSync low for exactly 384 clks and high for 2816 clks. vCount increments once at the hCount 799->0 wrap.
- **Visible window:** run a full frame -> bright first rises at (hCount=144, vCount=35) and last falls after (783, 514). Total bright clks per frame = 640*480*4 = 1,228,800.
- **Frame timing:** run 2 frames -> frame_tick pulses exactly once per 1,680,000 clks, each pulse at (799, 524) with pix_en high. vSync low for 6400 clks starting at (0,0).
- **Mid-frame reset:** assert rst for 1 clk at (400, 300) -> next cycle shows (0,0) with div=0. No frame_tick is emitted. The next frame_tick arrives 1,680,000 clks after the reset edge.
- **Counter hold:** sample hCount across the 3 non-`pix_en` clks of any pixel -> value unchanged.
